// File: rtl/read_module_pkg.sv
// Shared types and helpers for the FIFO read side.
// State encoding width matches the writer FSM.
package read_module_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    READ  = 3'b010,
    CHECK = 3'b011
  } state_t;

  // Zero-extension leaves parity unchanged, so any width up to 64 fits.
  function automatic logic odd_par(
    input logic [63:0] w
  );
    return ^w;
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v == max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/read_module_word_check.sv
// Per-word check rules: odd parity and forward modular ordering.
// Pure combinational so it can be exercised on its own.
module read_word_check
  import read_module_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] prev,
  input  logic              first,
  output logic              par_err,
  output logic              ord_err
);

  logic [DATA_W-1:0] diff;

  assign diff    = cur - prev;
  assign par_err = !odd_par(64'(cur));
  // Half-range rule tolerates counter wrap and writer-side drops.
  assign ord_err = !first &&
                   ((diff == '0) || diff[DATA_W-1]);

endmodule

// File: rtl/read_module.sv
// FIFO read-side consumer: pops one word per two cycles,
// checks parity and ordering, keeps error statistics.
module read_module
  import read_module_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              ren,
  input  logic              rempty,
  input  logic [DATA_W-1:0] rdata,
  output logic              rinc,
  output logic [DATA_W-1:0] last_data,
  output logic [15:0]       word_cnt,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  ord_err_cnt,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  state_t            nxt;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] prev;
  logic              first;
  logic              par_err;
  logic              ord_err;
  logic              avail;

  assign avail = ren && !rempty;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = avail ? READ : IDLE;
      READ:    nxt = CHECK;
      CHECK:   nxt = avail ? READ : IDLE;
      default: nxt = IDLE;
    endcase
  end

  read_word_check #(
    .DATA_W (DATA_W)
  ) u_check (
    .cur     (cap),
    .prev    (prev),
    .first   (first),
    .par_err (par_err),
    .ord_err (ord_err)
  );

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state       <= IDLE;
      rinc        <= 1'b0;
      cap         <= '0;
      prev        <= '0;
      first       <= 1'b1;
      last_data   <= '0;
      word_cnt    <= '0;
      par_err_cnt <= '0;
      ord_err_cnt <= '0;
      err         <= 1'b0;
    end else begin
      state <= nxt;
      rinc  <= (nxt == READ);
      if (state == READ) begin
        cap <= rdata;
      end
      if (state == CHECK) begin
        last_data <= cap;
        prev      <= cap;
        first     <= 1'b0;
        word_cnt  <= word_cnt + 16'd1;
        if (par_err) begin
          par_err_cnt <= CNT_W'(sat_inc(
            32'(par_err_cnt), 32'(CNT_MAX)));
        end
        if (ord_err) begin
          ord_err_cnt <= CNT_W'(sat_inc(
            32'(ord_err_cnt), 32'(CNT_MAX)));
        end
        // Sticky even when the counter is already pinned.
        if (par_err || ord_err) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_read_module.sv
// Bench for read_module: FIFO model, scoreboard of expected
// per-word results, table vectors and multi-cycle corner cases.
module tb_read_module;

  typedef struct {
    logic        rst;
    logic [15:0] w;
    logic        p;
    logic        o;
  } vec_t;

  typedef struct {
    logic [15:0] w;
    logic        p;
    logic        o;
  } exp_t;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        ren = 1'b0;
  logic        rempty;
  logic [15:0] rdata;
  logic        rinc;
  logic [15:0] last_data;
  logic [15:0] word_cnt;
  logic [7:0]  par_err_cnt;
  logic [7:0]  ord_err_cnt;
  logic        err;

  logic [15:0] mem [0:1023];
  int          wp = 0;
  int          rp = 0;
  exp_t        sb [$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses = 0;
  logic        rinc_q = 1'b0;
  logic [15:0] wc_q = '0;
  logic [15:0] exp_wc = '0;
  logic [7:0]  exp_par = '0;
  logic [7:0]  exp_ord = '0;
  logic        exp_err = 1'b0;
  logic [15:0] mprev = '0;
  logic        mfirst = 1'b1;
  vec_t        tbl [15];

  always #5 rclk = ~rclk;

  assign rempty = (wp == rp);
  assign rdata  = mem[rp[9:0]];

  always @(posedge rclk) begin
    if (rinc) rp <= rp + 1;
  end

  read_module #(
    .DATA_W (16),
    .CNT_W  (8)
  ) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .ren         (ren),
    .rempty      (rempty),
    .rdata       (rdata),
    .rinc        (rinc),
    .last_data   (last_data),
    .word_cnt    (word_cnt),
    .par_err_cnt (par_err_cnt),
    .ord_err_cnt (ord_err_cnt),
    .err         (err)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push(
    input logic [15:0] w,
    input logic        p,
    input logic        o
  );
    exp_t e;
    mem[wp[9:0]] = w;
    wp = wp + 1;
    e.w = w;
    e.p = p;
    e.o = o;
    sb.push_back(e);
  endtask

  task automatic push_model(input logic [15:0] w);
    logic [15:0] d;
    logic        p;
    logic        o;
    d = w - mprev;
    p = ~(^w);
    o = !mfirst && ((d == 16'd0) || d[15]);
    mprev  = w;
    mfirst = 1'b0;
    push(w, p, o);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rinc"}, 32'(rinc), 0);
    check({tag, "_last"}, 32'(last_data), 0);
    check({tag, "_wcnt"}, 32'(word_cnt), 0);
    check({tag, "_par"}, 32'(par_err_cnt), 0);
    check({tag, "_ord"}, 32'(ord_err_cnt), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    sb.delete();
    exp_wc  = '0;
    exp_par = '0;
    exp_ord = '0;
    exp_err = 1'b0;
    mprev   = '0;
    mfirst  = 1'b1;
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge rclk);
      if (sb.size() == 0 && wp == rp) break;
    end
    check("drain_timeout", 32'(k < 3000), 1);
  endtask

  // Scoreboard monitor: every word_cnt step retires one entry.
  always @(negedge rclk) begin
    exp_t e;
    if (rrst_n) begin
      if (rinc) begin
        pulses++;
        check("rinc_b2b", 32'(rinc_q), 0);
      end
      if (word_cnt != wc_q) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          exp_wc = exp_wc + 16'd1;
          if (e.p && exp_par != 8'hFF)
            exp_par = exp_par + 8'd1;
          if (e.o && exp_ord != 8'hFF)
            exp_ord = exp_ord + 8'd1;
          if (e.p || e.o) exp_err = 1'b1;
          check("last_data", 32'(last_data), 32'(e.w));
          check("word_cnt", 32'(word_cnt), 32'(exp_wc));
          check("par_cnt", 32'(par_err_cnt), 32'(exp_par));
          check("ord_cnt", 32'(ord_err_cnt), 32'(exp_ord));
          check("err", 32'(err), 32'(exp_err));
        end
      end
    end
    rinc_q = rinc;
    wc_q   = word_cnt;
  end

  initial begin
    logic [15:0] wc0;
    logic [15:0] w;
    int          p0;
    int          k;

    tbl[0]  = '{1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0004, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0003, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'h0008, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0004, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0007, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 16'h8000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1};

    do_reset();
    ren = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) begin
        drain();
        do_reset();
      end
      push(tbl[i].w, tbl[i].p, tbl[i].o);
    end
    drain();
    check("rinc_pulses", 32'(pulses), 15);

    // Latency from rempty falling to counter update.
    wc0 = exp_wc;
    push(16'h0010, 1'b0, 1'b0);
    @(negedge rclk);
    check("lat_rinc_hi", 32'(rinc), 1);
    @(negedge rclk);
    check("lat_rinc_lo", 32'(rinc), 0);
    check("lat_wc_hold", 32'(word_cnt), 32'(wc0));
    @(negedge rclk);
    check("lat_wc_step", 32'(word_cnt), 32'(wc0 + 16'd1));
    drain();

    // Saturation with even-parity increasing words.
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      w = 16'(i * 4);
      if (^w) w[0] = 1'b1;
      push_model(w);
    end
    drain();
    check("sat_par", 32'(par_err_cnt), 32'hFF);
    check("sat_wcnt", 32'(word_cnt), 300);
    check("sat_ord", 32'(ord_err_cnt), 0);
    check("sat_err", 32'(err), 1);

    // Stall with data present, then drop ren on the pop cycle.
    do_reset();
    ren = 1'b0;
    push(16'h0003, 1'b1, 1'b0);
    push(16'h0005, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      check("stall_rinc", 32'(rinc), 0);
    end
    p0 = pulses;
    ren = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge rclk);
      if (rinc) break;
    end
    check("stall_pop_seen", 32'(k < 20), 1);
    ren = 1'b0;
    repeat (12) @(negedge rclk);
    check("drop_pulses", 32'(pulses - p0), 1);
    check("drop_wcnt", 32'(word_cnt), 1);
    check("drop_par", 32'(par_err_cnt), 1);
    check("drop_err", 32'(err), 1);

    // Asynchronous reset in the middle of a pop.
    ren = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge rclk);
      if (rinc) break;
    end
    check("mid_pop_seen", 32'(k < 20), 1);
    rrst_n = 1'b0;
    #1;
    check_reset_vals("async");
    sb.delete();
    ren = 1'b0;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    repeat (5) @(negedge rclk);
    check("post_rst_rinc", 32'(rinc), 0);
    check("post_rst_wcnt", 32'(word_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
